// File: rtl/fetch_unit.sv
// Small in-order FIFO with synchronous flush, shared by the fetch address and instruction queues.
// Latency: a pushed entry becomes visible at the head one cycle after the push.
// Backpressure: none internally; the owner never pushes when full, and pops on empty are ignored.
module fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           push,
    input  logic [W-1:0]                   push_dat,
    input  logic                           pop,
    output logic [W-1:0]                   head_dat,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop   = pop && (count != '0);
    assign head_dat = mem[rd_ptr];

    // Storage, pointers and occupancy; flush empties without touching storage contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(push) - CW'(do_pop);
        end
    end
endmodule

// Instruction fetch front end: PC, imem request channel, 2-entry instruction buffer toward decode.
// Latency: a word is visible to decode the cycle after its memory response; startup is request, response, visible.
// Backpressure: requests stop when buffer+live requests or in-flight requests reach 2; decode stall freezes the head.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        do_branch,
    input  logic [31:0] branch_addr,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    output logic [31:0] pc4
);
    logic [31:0] pc;
    logic [1:0]  outstanding;   // live requests whose words will be kept
    logic [1:0]  drop;          // requests already abandoned by a redirect
    logic [1:0]  count;         // instruction buffer occupancy
    logic [1:0]  aq_count;      // address queue occupancy, always outstanding + drop
    logic [31:0] aq_head;
    logic [63:0] ibuf_head;
    logic [2:0]  credit_used;
    logic        req_fire;
    logic        resp_live;
    logic        resp_stale;
    logic        ibuf_push;
    logic        ibuf_pop;

    // A request needs a buffer slot reserved for its word and a free address-queue slot.
    assign credit_used    = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = !reset && !do_branch && (credit_used < 3'd2) && (aq_count < 2'd2);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Stale words (from before a redirect) always return ahead of live ones, so they drain first.
    assign resp_stale = imem_resp_valid && (drop != 2'd0);
    assign resp_live  = imem_resp_valid && (drop == 2'd0);
    assign ibuf_push  = resp_live && !do_branch;
    assign ibuf_pop   = inst_valid && inst_ready && !do_branch;

    assign inst_valid  = (count != 2'd0);
    assign instruction = ibuf_head[63:32];
    assign inst_pc     = ibuf_head[31:0];
    assign pc4         = inst_pc + 32'd4;

    // PC and in-flight bookkeeping; a redirect turns every live request into a stale one.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc          <= RESET_PC;
            outstanding <= 2'd0;
            drop        <= 2'd0;
        end else if (do_branch) begin
            pc          <= {branch_addr[31:2], 2'b00};
            outstanding <= 2'd0;
            drop        <= outstanding + drop - {1'b0, imem_resp_valid};
        end else begin
            if (req_fire) begin
                pc <= pc + 32'd4;
            end
            outstanding <= outstanding + {1'b0, req_fire} - {1'b0, resp_live};
            drop        <= drop - {1'b0, resp_stale};
        end
    end

    // Addresses of requests in flight; every response retires one, stale or not.
    fetch_fifo #(.W(32), .DEPTH(2)) u_addr_q (
        .clock    (clock),
        .reset    (reset),
        .flush    (1'b0),
        .push     (req_fire),
        .push_dat (pc),
        .pop      (imem_resp_valid),
        .head_dat (aq_head),
        .count    (aq_count)
    );

    // Returned {word, addr} pairs waiting for decode; emptied on redirect.
    fetch_fifo #(.W(64), .DEPTH(2)) u_ibuf (
        .clock    (clock),
        .reset    (reset),
        .flush    (do_branch),
        .push     (ibuf_push),
        .push_dat ({imem_resp_data, aq_head}),
        .pop      (ibuf_pop),
        .head_dat (ibuf_head),
        .count    (count)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: bench-side instruction memory with programmable latency and a stream model.
// The model says decode must see consecutive words from the reset PC or the latest redirect target.
// Each task drives one scenario and compares sampled outputs inline.
module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'h00400000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        do_branch = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic [31:0] pc4;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clock           (clock),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .do_branch       (do_branch),
        .branch_addr     (branch_addr),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .instruction     (instruction),
        .inst_pc         (inst_pc),
        .pc4             (pc4)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int last_due = 0;
    int delivered = 0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] exp_pc = RPC;
    logic [31:0] exp_req = RPC;

    logic        s_req_valid, s_fire, s_inst_valid, s_deliver;
    logic [31:0] s_req_addr, s_inst_pc, s_instruction, s_pc4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // One clock cycle: memory answers, outputs are sampled at negedge, the stream model is advanced.
    task automatic step();
        int d;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (!reset && mq_due.size() > 0 && mq_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        @(negedge clock);
        s_req_valid   = imem_req_valid;
        s_req_addr    = imem_req_addr;
        s_fire        = imem_req_valid && imem_req_ready;
        s_inst_valid  = inst_valid;
        s_inst_pc     = inst_pc;
        s_instruction = instruction;
        s_pc4         = pc4;
        s_deliver     = inst_valid && inst_ready && !do_branch;
        if (reset) begin
            checks++;
            if (imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL req_valid_in_reset: got %b want 0", imem_req_valid);
            end
            mq_addr.delete();
            mq_due.delete();
            last_due = 0;
            exp_pc   = RPC;
            exp_req  = RPC;
        end else begin
            if (do_branch) begin
                checks++;
                if (imem_req_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL req_during_redirect: got %b want 0", imem_req_valid);
                end
            end
            if (s_fire) begin
                checks++;
                if (s_req_addr !== exp_req) begin
                    errors++;
                    $display("FAIL req_addr_order: got %h want %h", s_req_addr, exp_req);
                end
                exp_req = exp_req + 32'd4;
                d = cyc + lat;
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                mq_addr.push_back(s_req_addr);
                mq_due.push_back(d);
            end
            if (s_deliver) begin
                checks++;
                if (s_inst_pc !== exp_pc || s_instruction !== mem_word(exp_pc) || s_pc4 !== exp_pc + 32'd4) begin
                    errors++;
                    $display("FAIL delivered_word: got pc=%h inst=%h pc4=%h want pc=%h inst=%h pc4=%h",
                             s_inst_pc, s_instruction, s_pc4, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (do_branch) begin
                exp_pc  = {branch_addr[31:2], 2'b00};
                exp_req = {branch_addr[31:2], 2'b00};
            end
            checks++;
            if (int'(dut.outstanding) + int'(dut.drop) > 2 ||
                int'(dut.count) + int'(dut.outstanding) > 2 ||
                int'(dut.u_addr_q.count) != int'(dut.outstanding) + int'(dut.drop)) begin
                errors++;
                $display("FAIL invariants: got out=%0d drop=%0d count=%0d aq=%0d want out+drop<=2 count+out<=2 aq==out+drop",
                         dut.outstanding, dut.drop, dut.count, dut.u_addr_q.count);
            end
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        do_branch = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        lat = 1; inst_ready = 1'b1; imem_req_ready = 1'b1;
        apply_reset();
        checks++;
        if (inst_valid !== 1'b0 || instruction !== 32'h0 || inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b inst=%h pc=%h want 0 0 0", inst_valid, instruction, inst_pc);
        end
        checks++;
        if (imem_req_addr !== RPC) begin
            errors++;
            $display("FAIL reset_pc: got %h want %h", imem_req_addr, RPC);
        end
        step();
        checks++;
        if (s_fire !== 1'b1 || s_req_addr !== RPC) begin
            errors++;
            $display("FAIL first_req: got fire=%b addr=%h want 1 %h", s_fire, s_req_addr, RPC);
        end
        step();
        checks++;
        if (s_fire !== 1'b1 || s_req_addr !== RPC + 32'd4 || s_inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL second_req: got fire=%b addr=%h v=%b want 1 %h 0", s_fire, s_req_addr, s_inst_valid, RPC + 32'd4);
        end
        step();
        checks++;
        if (s_inst_valid !== 1'b1 || s_inst_pc !== RPC || s_pc4 !== RPC + 32'd4) begin
            errors++;
            $display("FAIL first_visible: got v=%b pc=%h pc4=%h want 1 %h %h", s_inst_valid, s_inst_pc, s_pc4, RPC, RPC + 32'd4);
        end
    endtask

    task automatic test_stall();
        logic [31:0] p0, w0;
        step(); step();
        inst_ready = 1'b0;
        for (int i = 0; i < 6; i++) step();
        p0 = s_inst_pc;
        w0 = s_instruction;
        checks++;
        if (s_req_valid !== 1'b0 || s_inst_valid !== 1'b1 || dut.count !== 2'd2) begin
            errors++;
            $display("FAIL stall_full: got req_v=%b v=%b count=%0d want 0 1 2", s_req_valid, s_inst_valid, dut.count);
        end
        step();
        checks++;
        if (s_inst_pc !== p0 || s_instruction !== w0 || s_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_frozen: got pc=%h inst=%h req_v=%b want %h %h 0", s_inst_pc, s_instruction, s_req_valid, p0, w0);
        end
        inst_ready = 1'b1;
        step();
        checks++;
        if (s_deliver !== 1'b1 || s_inst_pc !== p0) begin
            errors++;
            $display("FAIL drain_first: got take=%b pc=%h want 1 %h", s_deliver, s_inst_pc, p0);
        end
        step();
        checks++;
        if (s_inst_valid !== 1'b1 || s_inst_pc !== p0 + 32'd4) begin
            errors++;
            $display("FAIL drain_second: got v=%b pc=%h want 1 %h", s_inst_valid, s_inst_pc, p0 + 32'd4);
        end
        for (int i = 0; i < 10; i++) step();
    endtask

    task automatic test_redirect_latency();
        bit found;
        lat = 3; inst_ready = 1'b1; imem_req_ready = 1'b1;
        apply_reset();
        step(); step();
        do_branch = 1'b1;
        branch_addr = 32'h00000103;
        step();
        do_branch = 1'b0;
        checks++;
        if (int'(dut.drop) != mq_addr.size() || dut.outstanding !== 2'd0 || mq_addr.size() != 2) begin
            errors++;
            $display("FAIL redirect_drop: got drop=%0d out=%0d want %0d 0 (pending=2)", dut.drop, dut.outstanding, mq_addr.size());
        end
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            if (s_fire) found = 1;
        end
        checks++;
        if (!found || s_req_addr !== 32'h00000100) begin
            errors++;
            $display("FAIL redirect_target_req: got found=%0d addr=%h want 1 00000100", found, s_req_addr);
        end
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (s_inst_valid) found = 1;
        end
        checks++;
        if (!found || s_inst_pc !== 32'h00000100) begin
            errors++;
            $display("FAIL redirect_first_inst: got found=%0d pc=%h want 1 00000100", found, s_inst_pc);
        end
    endtask

    task automatic test_redirect_collision();
        bit found = 0;
        lat = 1; inst_ready = 1'b1; imem_req_ready = 1'b1;
        apply_reset();
        for (int i = 0; i < 30 && !found; i++) begin
            if (inst_valid === 1'b1 && mq_due.size() > 0 && mq_due[0] <= cyc) found = 1;
            else step();
        end
        do_branch = 1'b1;
        branch_addr = $urandom & 32'h0FFFFFFF;
        step();
        do_branch = 1'b0;
        checks++;
        if (!found || inst_valid !== 1'b0 || int'(dut.drop) != mq_addr.size() || dut.outstanding !== 2'd0) begin
            errors++;
            $display("FAIL redirect_collision: got found=%0d v=%b drop=%0d out=%0d want 1 0 %0d 0",
                     found, inst_valid, dut.drop, dut.outstanding, mq_addr.size());
        end
        for (int i = 0; i < 20; i++) step();
    endtask

    task automatic test_wrap();
        bit seen_last = 0, got_next = 0, got_pc4 = 0;
        logic [31:0] next_addr = 32'hDEADBEEF, last_pc4 = 32'hDEADBEEF;
        lat = 1; inst_ready = 1'b1; imem_req_ready = 1'b1;
        do_branch = 1'b1;
        branch_addr = 32'hFFFFFFF8;
        step();
        do_branch = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (s_fire && seen_last && !got_next) begin
                got_next = 1;
                next_addr = s_req_addr;
            end
            if (s_fire && s_req_addr == 32'hFFFFFFFC) seen_last = 1;
            if (s_deliver && s_inst_pc == 32'hFFFFFFFC) begin
                got_pc4 = 1;
                last_pc4 = s_pc4;
            end
        end
        checks++;
        if (!got_next || next_addr !== 32'h00000000) begin
            errors++;
            $display("FAIL wrap_req: got found=%0d addr=%h want 1 00000000", got_next, next_addr);
        end
        checks++;
        if (!got_pc4 || last_pc4 !== 32'h00000000) begin
            errors++;
            $display("FAIL wrap_pc4: got found=%0d pc4=%h want 1 00000000", got_pc4, last_pc4);
        end
    endtask

    task automatic test_reset_midstream();
        lat = 3;
        for (int i = 0; i < 15; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 2) == 0);
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        checks++;
        if (dut.outstanding !== 2'd0 || dut.drop !== 2'd0 || dut.count !== 2'd0 || dut.u_addr_q.count !== 2'd0) begin
            errors++;
            $display("FAIL midreset_counters: got out=%0d drop=%0d count=%0d aq=%0d want 0 0 0 0",
                     dut.outstanding, dut.drop, dut.count, dut.u_addr_q.count);
        end
        checks++;
        if (imem_req_addr !== RPC || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_pc: got addr=%h v=%b want %h 0", imem_req_addr, inst_valid, RPC);
        end
        for (int i = 0; i < 30; i++) step();
    endtask

    task automatic test_random();
        int start = delivered;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) lat = $urandom_range(1, 4);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 3) != 0);
            do_branch      = ($urandom_range(0, 29) == 0);
            branch_addr    = $urandom;
            step();
        end
        do_branch = 1'b0;
        checks++;
        if (delivered - start < 200) begin
            errors++;
            $display("FAIL random_progress: got %0d words want at least 200", delivered - start);
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect_latency();
        test_redirect_collision();
        test_wrap();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
